// File: rtl/regfile_mp_pkg.sv
// Shared defaults and FSM state encoding for the multi-port register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_mp_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int NRD_DEF  = 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_mp_rdport.sv
// One registered read port: entry select, entry-0 zeroing, optional write forwarding.
// Latency: 1 cycle from en to dat; dat holds while en is low.
// Backpressure: none; reads while the file is clearing return 0.
// Forwarding of the same-cycle write is compiled in with REGFILE_MP_BYPASS_EN.
module regfile_mp_rdport #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic                      en,
  input  logic [AW-1:0]             addr,
  input  logic [NREG-1:0][XLEN-1:0] entries,
  input  logic                      wr_fire,
  input  logic [AW-1:0]             wr_addr,
  input  logic [XLEN-1:0]           wr_data,
  output logic [XLEN-1:0]           dat
);

  logic [XLEN-1:0] entry;
  logic            hit;

  assign entry = entries[addr];

`ifdef REGFILE_MP_BYPASS_EN
  // A write landing this edge at our address is returned instead of the stale entry.
  assign hit = wr_fire && (wr_addr == addr);
`else
  // Without forwarding the read sees the value stored before this edge.
  logic unused_wr;
  assign unused_wr = ^{wr_fire, wr_addr, wr_data};
  assign hit = 1'b0;
`endif

  // Output register: loads only when enabled, zero for entry 0 and while clearing.
  always_ff @(posedge clk) begin
    if (rst) begin
      dat <= '0;
    end else if (en) begin
      if (!run || addr == '0) begin
        dat <= '0;
      end else if (hit) begin
        dat <= wr_data;
      end else begin
        dat <= entry;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Register file with one write port, NRD registered read ports and a clearing sweep.
// Latency: writes land on the edge, reads return 1 cycle later; ready rises NREG+1 edges after a clear starts.
// Backpressure: while ready is low, writes are dropped and reads return 0.
// Optional macro REGFILE_MP_BYPASS_EN forwards a same-cycle write to matching reads.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = NRD_DEF,
  localparam int AW  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic [NRD-1:0]    rd_en,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic              clr_req,
  output logic              ready
);

  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  state_t                    state;
  logic [AW-1:0]             clr_cnt;
  logic                      sweep_done;
  logic [NREG-1:0][XLEN-1:0] mem;

  logic run;
  logic sweep_we;
  logic wr_fire;

  assign run      = (state == ST_RUN);
  // The last entry is written on the edge that sets sweep_done; the following
  // edge only moves to RUN so the counter never wraps.
  assign sweep_we = (state == ST_CLEAR) && !sweep_done;
  // A clear request in the same cycle wins over the write.
  assign wr_fire  = run && wr_en && !clr_req;

  // Sweep/run controller with registered ready mirroring the RUN state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_CLEAR;
      clr_cnt    <= '0;
      sweep_done <= 1'b0;
      ready      <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (sweep_done) begin
            state      <= ST_RUN;
            ready      <= 1'b1;
            sweep_done <= 1'b0;
          end else if (clr_cnt == LAST) begin
            sweep_done <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (clr_req) begin
            state   <= ST_CLEAR;
            ready   <= 1'b0;
            clr_cnt <= '0;
          end
        end
        default: begin
          state <= ST_CLEAR;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage update: the sweep zeroes one entry per cycle, otherwise accepted writes
  // land; entry 0 is never written with data. Contents have no reset of their own.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (sweep_we) begin
        mem[clr_cnt] <= '0;
      end else if (wr_fire && wr_addr != '0) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    regfile_mp_rdport #(
      .XLEN (XLEN),
      .NREG (NREG)
    ) u_rdport (
      .clk     (clk),
      .rst     (rst),
      .run     (run),
      .en      (rd_en[p]),
      .addr    (rd_addr[p*AW +: AW]),
      .entries (mem),
      .wr_fire (wr_fire),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .dat     (rd_data[p*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: stimulus pushes expected read data into a
// scoreboard; a monitor pops and compares one cycle after each enabled read.
// Control-path checks (ready timing, reset values, hold) are compared inline.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                 clk;
  logic                 rst;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [XLEN-1:0]      wr_data;
  logic [NRD-1:0]       rd_en;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic                 clr_req;
  logic                 ready;

  int tests;
  int fails;

  typedef struct {
    int          port;
    int          id;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  regfile_mp #(
    .XLEN (XLEN),
    .NREG (NREG),
    .NRD  (NRD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .clr_req (clr_req),
    .ready   (ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  // Schedule a read on port p for the coming edge and record what it must return.
  task automatic issue(input int p, input logic [AW-1:0] a, input logic [31:0] v, input int id);
    rd_en[p] = 1'b1;
    rd_addr[p*AW +: AW] = a;
    sb.push_back('{port: p, id: id, val: v});
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    rd_en = '0;
  endtask

  // Follow a sweep that started at the previous edge: ready must stay low for
  // NREG edges and be high after edge NREG+1. Optional side stimulus at given edges.
  task automatic watch_sweep(input string nm, input bit chk_zero,
                             input int rd_k, input int clr_k, input int wr_k);
    for (int k = 1; k <= NREG + 1; k++) begin
      if (k == rd_k)  issue(0, 5'd5, 32'h0, 100 + k);
      if (k == clr_k) clr_req = 1'b1;
      if (k == wr_k) begin
        wr_en   = 1'b1;
        wr_addr = 5'd9;
        wr_data = 32'hFF;
      end
      @(negedge clk);
      rd_en   = '0;
      clr_req = 1'b0;
      wr_en   = 1'b0;
      chk($sformatf("%s_ready_e%0d", nm, k), {31'b0, ready}, {31'b0, (k == NREG + 1)});
      if (chk_zero) chk($sformatf("%s_rdzero_e%0d", nm, k), rd_data[31:0] | rd_data[63:32], 32'h0);
    end
  endtask

  // Monitor: for each port enabled at an edge, match the oldest pending expectation.
  initial begin
    logic [NRD-1:0] en_s;
    forever begin
      @(posedge clk);
      en_s = rd_en;
      #1;
      for (int p = 0; p < NRD; p++) begin
        if (en_s[p]) begin
          int idx;
          idx = -1;
          for (int i = 0; i < sb.size(); i++) begin
            if (idx < 0 && sb[i].port == p) idx = i;
          end
          if (idx < 0) begin
            tests++;
            fails++;
            $display("FAIL sb_underflow port%0d got=%h want=no_read", p, rd_data[p*XLEN +: XLEN]);
          end else begin
            chk($sformatf("rd_p%0d_id%0d", p, sb[idx].id), rd_data[p*XLEN +: XLEN], sb[idx].val);
            sb.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    tests   = 0;
    fails   = 0;
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_en   = '0;
    rd_addr = '0;
    clr_req = 1'b0;

    // Reset, then the power-on sweep.
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 32'h0);
    chk("rst_rd0", rd_data[31:0], 32'h0);
    chk("rst_rd1", rd_data[63:32], 32'h0);
    rst = 1'b0;
    watch_sweep("init", 1'b1, 0, 0, 0);

    // Dual-port read of the same entry.
    wr(5'd5, 32'hDEADBEEF);
    issue(0, 5'd5, 32'hDEADBEEF, 1);
    issue(1, 5'd5, 32'hDEADBEEF, 2);
    step();

    // Entry 0 discards writes and reads as zero.
    wr(5'd0, 32'h12345678);
    issue(0, 5'd0, 32'h0, 3);
    issue(1, 5'd0, 32'h0, 4);
    step();

    // Same-cycle write and read of x7.
    wr(5'd7, 32'h00000001);
    wr_en   = 1'b1;
    wr_addr = 5'd7;
    wr_data = 32'hA5A5A5A5;
`ifdef REGFILE_MP_BYPASS_EN
    issue(0, 5'd7, 32'hA5A5A5A5, 5);
`else
    issue(0, 5'd7, 32'h00000001, 5);
`endif
    step();
    wr_en = 1'b0;
    issue(1, 5'd7, 32'hA5A5A5A5, 6);
    step();

    // Different addresses on the two ports, then port 1 must hold while idle.
    wr(5'd9, 32'h00000099);
    issue(0, 5'd9, 32'h00000099, 7);
    issue(1, 5'd5, 32'hDEADBEEF, 8);
    step();
    issue(0, 5'd7, 32'hA5A5A5A5, 9);
    step();
    chk("hold_p1", rd_data[63:32], 32'hDEADBEEF);
    step();
    chk("hold_p0", rd_data[31:0], 32'hA5A5A5A5);

    // Clear request colliding with a write; mid-sweep read, ignored clr_req and dropped write.
    clr_req = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 5'd3;
    wr_data = 32'h55;
    @(negedge clk);
    clr_req = 1'b0;
    wr_en   = 1'b0;
    watch_sweep("clr", 1'b0, 5, 10, 20);
    issue(0, 5'd3, 32'h0, 10);
    issue(1, 5'd9, 32'h0, 11);
    step();
    issue(0, 5'd5, 32'h0, 12);
    step();

    // Reset in the middle of a sweep restarts it and zeroes the outputs.
    wr(5'd5, 32'hCAFEF00D);
    issue(0, 5'd5, 32'hCAFEF00D, 13);
    issue(1, 5'd5, 32'hCAFEF00D, 14);
    step();
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", {31'b0, ready}, 32'h0);
    chk("midrst_rd0", rd_data[31:0], 32'h0);
    chk("midrst_rd1", rd_data[63:32], 32'h0);
    watch_sweep("midrst", 1'b1, 0, 0, 0);
    issue(0, 5'd5, 32'h0, 15);
    issue(1, 5'd31, 32'h0, 16);
    step();

    // Writes after the sweep work again at the top entry.
    wr(5'd31, 32'h80000001);
    issue(1, 5'd31, 32'h80000001, 17);
    step();
    step();

    chk("sb_drained", sb.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
